// File: rtl/uart_tx_fifo.sv
// Byte FIFO between the MMIO write path and the UART transmitter.
// First-word fall-through head, occupancy count and sticky overflow for status reads.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         enq_data,
    input  logic                     enq_valid,
    output logic                     enq_ready,
    output logic [WIDTH-1:0]         deq_data,
    output logic                     deq_valid,
    input  logic                     deq_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     clear_overflow
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;
    localparam logic [ADDR_W:0]  PTR_ONE = (ADDR_W + 1)'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [ADDR_W:0]  wr_ptr;
    logic [ADDR_W:0]  rd_ptr;
    logic             empty;
    logic             full;
    logic             enq_fire;
    logic             deq_fire;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (rd_ptr == wr_ptr);
    assign full  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                   (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);

    assign enq_ready = !full;
    assign deq_valid = !empty;
    assign deq_data  = mem[rd_ptr[ADDR_W-1:0]];

    assign enq_fire = enq_valid && enq_ready;
    assign deq_fire = deq_valid && deq_ready;

    always_ff @(posedge clk) begin
        if (enq_fire && !reset) begin
            mem[wr_ptr[ADDR_W-1:0]] <= enq_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (enq_fire) wr_ptr <= wr_ptr + PTR_ONE;
            if (deq_fire) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else begin
            case ({enq_fire, deq_fire})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // A rejected write in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (enq_valid && !enq_ready) begin
            overflow <= 1'b1;
        end else if (clear_overflow) begin
            overflow <= 1'b0;
        end
    end

endmodule
